// File: rtl/clk_pkg.sv
// Shared definitions for the clock source controller: state encoding,
// diagnostic function codes, LDSRC operand layout and status bit positions.
package clk_pkg;

  typedef enum logic [1:0] {
    ST_STOP  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STEP  = 2'd2,
    ST_BURST = 2'd3
  } clk_state_e;

  localparam logic [2:0] FN_NOP     = 3'd0;
  localparam logic [2:0] FN_START   = 3'd1;
  localparam logic [2:0] FN_STOP    = 3'd2;
  localparam logic [2:0] FN_STEP    = 3'd3;
  localparam logic [2:0] FN_LDBURST = 3'd4;
  localparam logic [2:0] FN_BURST   = 3'd5;
  localparam logic [2:0] FN_LDSRC   = 3'd6;
  localparam logic [2:0] FN_CLRERR  = 3'd7;

  // LDSRC operand layout
  localparam int SRC_BIT  = 0;
  localparam int RATE_LSB = 1;
  localparam int RATE_MSB = 2;

  // Status readback layout: {err_stopped, src_ext, rate[1:0], state[1:0]}
  localparam int STAT_ERR      = 5;
  localparam int STAT_SRC      = 4;
  localparam int STAT_RATE_MSB = 3;
  localparam int STAT_RATE_LSB = 2;
  localparam int STAT_ST_MSB   = 1;
  localparam int STAT_ST_LSB   = 0;

  // Terminal divider value for a rate code: 2^rate - 1
  function automatic logic [2:0] rate_mask(input logic [1:0] rate);
    case (rate)
      2'd0:    rate_mask = 3'd0;
      2'd1:    rate_mask = 3'd1;
      2'd2:    rate_mask = 3'd3;
      default: rate_mask = 3'd7;
    endcase
  endfunction

endpackage

// File: rtl/clk_src_ctl_if.sv
// Diagnostic function bus: strobe, code and operand toward the controller,
// status readback toward the EBUS.
interface clk_src_ctl_if;
  logic       diag_func_l;
  logic [2:0] diag_func_code;
  logic [7:0] ebus_ds_data_h;
  logic [5:0] clk_status_h;

  modport master (output diag_func_l, diag_func_code, ebus_ds_data_h,
                  input  clk_status_h);
  modport slave  (input  diag_func_l, diag_func_code, ebus_ds_data_h,
                  output clk_status_h);
endinterface

// File: rtl/clk_src_sync.sv
// Brings the asynchronous external timebase into the clk domain and
// produces a one-cycle pulse per rising edge.
module clk_src_sync (
  input  logic clk,
  input  logic mr_reset_l,
  input  logic external_clk_h,
  output logic rise
);
  logic meta, sync, edge_q;

  // Two-flop synchronizer followed by the edge-detect history flop
  always_ff @(posedge clk) begin
    if (!mr_reset_l) begin
      meta   <= 1'b0;
      sync   <= 1'b0;
      edge_q <= 1'b0;
    end else begin
      meta   <= external_clk_h;
      sync   <= meta;
      edge_q <= sync;
    end
  end

  assign rise = sync & ~edge_q;
endmodule

// File: rtl/clk_src_ctl.sv
// Clock source and diagnostic burst controller: selects the timebase,
// divides it, and gates the machine tick by RUN/STOP/STEP/BURST mode.
module clk_src_ctl
  import clk_pkg::*;
#(
  parameter int BURST_W = 8,
  parameter int DIV_W   = 3
) (
  input  logic               clk,
  input  logic               mr_reset_l,
  clk_src_ctl_if.slave       bus,
  input  logic               external_clk_h,
  input  logic               clk_error_stop_h,
  input  logic               error_stop_en_h,
  output logic               clk1_clk_h,
  output logic               clk_running_h,
  output logic [BURST_W-1:0] clk_burst_cnt_h,
  output logic               clk_burst_done_h
);
  clk_state_e         state, state_n;
  logic               src_ext;
  logic [1:0]         rate;
  logic [DIV_W-1:0]   div_cnt;
  logic               err_stopped, err_n;
  logic [BURST_W-1:0] cnt_n;
  logic               done_n;
  logic               ext_rise, base_tick, div_tick, issue, err_hit, act, ld_src;
  logic [5:0]         status;

  clk_src_sync u_sync (
    .clk            (clk),
    .mr_reset_l     (mr_reset_l),
    .external_clk_h (external_clk_h),
    .rise           (ext_rise)
  );

  // Tick qualification; an error stop suppresses the tick and masks strobes
  always_comb begin
    err_hit   = error_stop_en_h && clk_error_stop_h && (state != ST_STOP);
    act       = !bus.diag_func_l && !err_hit;
    ld_src    = act && (bus.diag_func_code == FN_LDSRC);
    base_tick = src_ext ? ext_rise : 1'b1;
    div_tick  = base_tick && (div_cnt == DIV_W'(rate_mask(rate)));
    issue     = div_tick && (state != ST_STOP) && !err_hit;
  end

  // Timebase selection and rate divider
  always_ff @(posedge clk) begin
    if (!mr_reset_l) begin
      src_ext <= 1'b0;
      rate    <= 2'd0;
      div_cnt <= '0;
    end else if (ld_src) begin
      src_ext <= bus.ebus_ds_data_h[SRC_BIT];
      rate    <= bus.ebus_ds_data_h[RATE_MSB:RATE_LSB];
      div_cnt <= '0;
    end else if (base_tick) begin
      div_cnt <= div_tick ? '0 : div_cnt + DIV_W'(1);
    end
  end

  // Next-state: error stop first, then tick consequences, then the strobe
  always_comb begin
    state_n = state;
    cnt_n   = clk_burst_cnt_h;
    err_n   = err_stopped;
    done_n  = 1'b0;
    if (err_hit) begin
      state_n = ST_STOP;
      err_n   = 1'b1;
    end else begin
      if (issue && state == ST_STEP) state_n = ST_STOP;
      if (issue && state == ST_BURST) begin
        cnt_n = clk_burst_cnt_h - BURST_W'(1);
        if (clk_burst_cnt_h == BURST_W'(1)) begin
          state_n = ST_STOP;
          done_n  = 1'b1;
        end
      end
      if (act) begin
        case (bus.diag_func_code)
          FN_START: if (state == ST_STOP && !err_stopped) state_n = ST_RUN;
          FN_STOP:  state_n = ST_STOP;
          FN_STEP:  if (state == ST_STOP && !err_stopped) state_n = ST_STEP;
          FN_BURST: begin
            if (state == ST_STOP && !err_stopped) begin
              if (clk_burst_cnt_h != '0) state_n = ST_BURST;
              else                       done_n  = 1'b1;
            end
          end
          FN_LDBURST: if (state != ST_BURST) cnt_n = BURST_W'(bus.ebus_ds_data_h);
          FN_CLRERR:  err_n = 1'b0;
          FN_NOP, FN_LDSRC: ;
          default: ;
        endcase
      end
    end
  end

  // Mode state, burst counter and registered tick/done outputs
  always_ff @(posedge clk) begin
    if (!mr_reset_l) begin
      state            <= ST_STOP;
      clk_burst_cnt_h  <= '0;
      err_stopped      <= 1'b0;
      clk_burst_done_h <= 1'b0;
      clk1_clk_h       <= 1'b0;
    end else begin
      state            <= state_n;
      clk_burst_cnt_h  <= cnt_n;
      err_stopped      <= err_n;
      clk_burst_done_h <= done_n;
      clk1_clk_h       <= issue;
    end
  end

  // Status readback assembly
  always_comb begin
    status                              = '0;
    status[STAT_ERR]                    = err_stopped;
    status[STAT_SRC]                    = src_ext;
    status[STAT_RATE_MSB:STAT_RATE_LSB] = rate;
    status[STAT_ST_MSB:STAT_ST_LSB]     = state;
  end

  assign bus.clk_status_h = status;
  assign clk_running_h    = (state == ST_RUN) || (state == ST_BURST);
endmodule

// File: tb/tb_clk_src_ctl.sv
// Directed and randomized bench for clk_src_ctl. Outputs are sampled on the
// falling edge; inputs change on the falling edge.
module tb_clk_src_ctl;
  logic       clk = 1'b0;
  logic       mr_reset_l;
  logic       external_clk_h;
  logic       clk_error_stop_h;
  logic       error_stop_en_h;
  logic       clk1;
  logic       running;
  logic [7:0] bcnt;
  logic       done;
  int         total = 0;
  int         bad = 0;
  int         cyc = 0;

  clk_src_ctl_if bus();

  clk_src_ctl dut (
    .clk              (clk),
    .mr_reset_l       (mr_reset_l),
    .bus              (bus),
    .external_clk_h   (external_clk_h),
    .clk_error_stop_h (clk_error_stop_h),
    .error_stop_en_h  (error_stop_en_h),
    .clk1_clk_h       (clk1),
    .clk_running_h    (running),
    .clk_burst_cnt_h  (bcnt),
    .clk_burst_done_h (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one diagnostic function; returns on the falling edge after the
  // strobe was captured.
  task automatic fn(input logic [2:0] code, input logic [7:0] data);
    bus.diag_func_code = code;
    bus.ebus_ds_data_h = data;
    bus.diag_func_l    = 1'b0;
    @(negedge clk);
    bus.diag_func_l    = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin : stim
    int ticks, dones, last, gaps_bad, r, n, p, rise_cyc, dly, ext_ok;
    mr_reset_l = 1'b0; external_clk_h = 1'b0;
    clk_error_stop_h = 1'b0; error_stop_en_h = 1'b0;
    bus.diag_func_l = 1'b1; bus.diag_func_code = 3'd0; bus.ebus_ds_data_h = 8'd0;
    idle(3);
    chk("rst_clk1", clk1, 0);
    chk("rst_status", bus.clk_status_h, 0);
    chk("rst_cnt", bcnt, 0);
    chk("rst_done", done, 0);
    chk("rst_running", running, 0);
    mr_reset_l = 1'b1;
    idle(1);

    // RUN at /1: ticks every cycle beginning two cycles after START
    fn(3'd6, 8'h00);
    fn(3'd1, 8'h00);
    chk("run1_first_lat", clk1, 0);
    @(negedge clk);
    chk("run1_first_tick", clk1, 1);
    chk("run1_status", bus.clk_status_h, 6'b000001);
    chk("run1_running", running, 1);
    ticks = 0;
    for (int i = 0; i < 6; i++) begin @(negedge clk); if (clk1) ticks++; end
    chk("run1_every_cycle", ticks, 6);
    fn(3'd2, 8'h00);
    idle(1);
    ticks = 0;
    for (int i = 0; i < 10; i++) begin @(negedge clk); if (clk1) ticks++; end
    chk("run1_stop_ticks", ticks, 0);
    chk("run1_stop_state", bus.clk_status_h[1:0], 0);

    // RUN at /4: tick spacing is four cycles
    fn(3'd6, 8'h04);
    fn(3'd1, 8'h00);
    idle(1);
    ticks = 0; last = -1; gaps_bad = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (clk1) begin
        if (last >= 0 && cyc - last != 4) gaps_bad++;
        last = cyc; ticks++;
      end
    end
    chk("run4_ticks", ticks, 4);
    chk("run4_gaps", gaps_bad, 0);
    chk("run4_status_rate", bus.clk_status_h[3:2], 2);
    fn(3'd2, 8'h00);
    idle(1);
    ticks = 0;
    for (int i = 0; i < 12; i++) begin @(negedge clk); if (clk1) ticks++; end
    chk("run4_stop_ticks", ticks, 0);
    chk("run4_stop_state", bus.clk_status_h[1:0], 0);

    // BURST of 5 at /1
    fn(3'd6, 8'h00);
    fn(3'd4, 8'd5);
    chk("b5_loaded", bcnt, 5);
    fn(3'd5, 8'h00);
    ticks = 0; dones = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (clk1) ticks++;
      chk("b5_count", bcnt, 5 - ticks);
      if (done) begin
        dones++;
        chk("b5_done_at_zero", bcnt, 0);
        chk("b5_done_with_tick", clk1, 1);
      end
    end
    chk("b5_ticks", ticks, 5);
    chk("b5_dones", dones, 1);
    chk("b5_state", bus.clk_status_h[1:0], 0);
    chk("b5_running", running, 0);

    // BURST with zero count: immediate done pulse, no ticks
    fn(3'd4, 8'd0);
    fn(3'd5, 8'h00);
    chk("b0_done", done, 1);
    chk("b0_state", bus.clk_status_h[1:0], 0);
    ticks = 0; dones = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (clk1) ticks++;
      if (done) dones++;
    end
    chk("b0_ticks", ticks, 0);
    chk("b0_extra_dones", dones, 0);

    // Error stop during a burst of 10 after three ticks
    fn(3'd4, 8'd10);
    fn(3'd5, 8'h00);
    ticks = 0;
    for (int i = 0; i < 20 && ticks < 3; i++) begin
      @(negedge clk);
      if (clk1) ticks++;
    end
    chk("err_reach3", ticks, 3);
    clk_error_stop_h = 1'b1; error_stop_en_h = 1'b1;
    @(negedge clk);
    chk("err_tick_suppressed", clk1, 0);
    clk_error_stop_h = 1'b0; error_stop_en_h = 1'b0;
    for (int i = 0; i < 6; i++) begin @(negedge clk); if (clk1) ticks++; end
    chk("err_at_most3", ticks <= 3, 1);
    chk("err_state", bus.clk_status_h[1:0], 0);
    chk("err_flag", bus.clk_status_h[5], 1);
    chk("err_cnt_held", bcnt, 7);
    fn(3'd1, 8'h00);
    chk("err_start_ignored", bus.clk_status_h[1:0], 0);
    ticks = 0;
    for (int i = 0; i < 4; i++) begin @(negedge clk); if (clk1) ticks++; end
    chk("err_no_ticks", ticks, 0);
    fn(3'd7, 8'h00);
    chk("clrerr_flag", bus.clk_status_h[5], 0);
    fn(3'd1, 8'h00);
    chk("clrerr_start", bus.clk_status_h[1:0], 1);
    chk("clrerr_running", running, 1);
    fn(3'd2, 8'h00);
    idle(2);

    // External timebase, one STEP: single tick 3..4 cycles after a rising edge
    fn(3'd6, 8'h01);
    chk("ext_status_src", bus.clk_status_h[4], 1);
    fn(3'd3, 8'h00);
    ticks = 0; rise_cyc = -1; dly = -1;
    for (int i = 0; i < 40; i++) begin
      if (((i / 5) % 2) == 1 && external_clk_h == 1'b0) begin
        if (rise_cyc < 0) rise_cyc = cyc;
      end
      external_clk_h = ((i / 5) % 2) == 1;
      @(negedge clk);
      if (clk1) begin
        ticks++;
        if (dly < 0) dly = cyc - rise_cyc;
      end
    end
    external_clk_h = 1'b0;
    ext_ok = (dly >= 3 && dly <= 4) ? 1 : 0;
    chk("ext_step_ticks", ticks, 1);
    chk("ext_step_latency", ext_ok, 1);
    chk("ext_step_state", bus.clk_status_h[1:0], 0);

    // Randomized bursts at random rates against the burst rules
    for (int k = 0; k < 6; k++) begin
      r = $urandom_range(0, 3);
      n = $urandom_range(1, 12);
      p = 1 << r;
      fn(3'd6, 8'(r << 1));
      fn(3'd4, 8'(n));
      fn(3'd5, 8'h00);
      ticks = 0; dones = 0; last = -1; gaps_bad = 0;
      for (int i = 0; i < n * p + 12; i++) begin
        @(negedge clk);
        if (clk1) begin
          if (last >= 0 && cyc - last != p) gaps_bad++;
          last = cyc; ticks++;
        end
        if (done) begin
          dones++;
          chk("rnd_done_at_zero", bcnt, 0);
        end
      end
      chk("rnd_ticks", ticks, n);
      chk("rnd_dones", dones, 1);
      chk("rnd_gaps", gaps_bad, 0);
      chk("rnd_state", bus.clk_status_h[1:0], 0);
    end

    // Reset in the middle of a burst
    fn(3'd6, 8'h00);
    fn(3'd4, 8'd20);
    fn(3'd5, 8'h00);
    idle(3);
    mr_reset_l = 1'b0;
    @(negedge clk);
    chk("mrst_cnt", bcnt, 0);
    chk("mrst_status", bus.clk_status_h, 0);
    chk("mrst_clk1", clk1, 0);
    chk("mrst_done", done, 0);
    mr_reset_l = 1'b1;
    ticks = 0; dones = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (clk1) ticks++;
      if (done) dones++;
    end
    chk("mrst_no_ticks", ticks, 0);
    chk("mrst_no_done", dones, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
